// File: rtl/adc_conv_arbiter.sv
// Round-robin arbiter that shares one serial-ADC core between NREQ requesters.
// Each job drops the stale first conversions, averages 2^AVG_LOG2 samples and returns the mean.
module adc_conv_arbiter #(
    parameter int NREQ     = 4,
    parameter int DISCARD  = 2,
    parameter int AVG_LOG2 = 5,
    parameter int TIMEOUT  = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] chan,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [11:0]       result,
    output logic              busy,
    output logic              en_adc,
    output logic [7:0]        din_address,
    input  logic              adc_state,
    input  logic [11:0]       adc_out
);
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NSAMP = DISCARD + (1 << AVG_LOG2);
    localparam int CW    = $clog2(NSAMP + 1);
    localparam int WW    = $clog2(TIMEOUT + 1);
    localparam int AW    = 12 + AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CONV,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [3:0]      chan_q, chan_d;
    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic [CW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [11:0]     result_q, result_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [3:0]      pick_chan;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_inc;
    logic            ce;

    assign ce      = !s1_q && s2_q;
    assign win_oh  = NREQ'(1) << win_q;
    assign win_inc = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
    assign result  = result_q;

    // Scan downwards so the requester closest to the pointer is the last (winning) assignment.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_chan  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(ptr_q) + k) % NREQ);
                pick_chan  = chan[((int'(ptr_q) + k) % NREQ) * 4 +: 4];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        chan_d      = chan_q;
        samp_cnt_d  = samp_cnt_q;
        acc_d       = acc_q;
        wdog_d      = wdog_q;
        result_d    = result_q;
        s1_d        = adc_state;
        s2_d        = s1_q;
        grant       = '0;
        done        = '0;
        err         = '0;
        en_adc      = 1'b0;
        din_address = 8'hFF;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                s1_d = 1'b0;
                s2_d = 1'b0;
                if (pick_found) begin
                    win_d   = pick_idx;
                    chan_d  = pick_chan;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                grant       = win_oh;
                en_adc      = 1'b1;
                din_address = {chan_q, 4'b1000};
                samp_cnt_d  = '0;
                acc_d       = '0;
                wdog_d      = WW'(1);
                state_d     = S_CONV;
            end
            S_CONV: begin
                grant       = win_oh;
                en_adc      = 1'b1;
                din_address = {chan_q, 4'b1000};
                if (!req[win_q]) begin
                    ptr_d   = win_inc;
                    state_d = S_IDLE;
                end else if (ce) begin
                    // wdog counts the cycle it is in, so ERR lands exactly TIMEOUT cycles after a ce.
                    samp_cnt_d = samp_cnt_q + 1'b1;
                    wdog_d     = WW'(1);
                    if (samp_cnt_q >= CW'(DISCARD)) begin
                        acc_d = acc_q + AW'(adc_out);
                    end
                    if (samp_cnt_q == CW'(NSAMP - 1)) begin
                        // Loaded here so result is already valid while done pulses.
                        result_d = acc_d[AW-1:AVG_LOG2];
                        state_d  = S_DONE;
                    end
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_DONE: begin
                grant   = win_oh;
                done    = win_oh;
                ptr_d   = win_inc;
                state_d = S_IDLE;
            end
            S_ERR: begin
                grant   = win_oh;
                err     = win_oh;
                ptr_d   = win_inc;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            chan_q     <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            samp_cnt_q <= '0;
            acc_q      <= '0;
            wdog_q     <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            chan_q     <= chan_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            samp_cnt_q <= samp_cnt_d;
            acc_q      <= acc_d;
            wdog_q     <= wdog_d;
            result_q   <= result_d;
        end
    end
endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Bench for adc_conv_arbiter: directed job sequence plus random requests, checked against
// a round-robin / averaging reference model built from queues and plain arithmetic.
module tb_adc_conv_arbiter;
    localparam int NREQ    = 4;
    localparam int DISCARD = 2;
    localparam int AVG_A   = 2;
    localparam int NA      = 1 << AVG_A;
    localparam int TMO     = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] chan = '0;
    logic [NREQ-1:0]   grant, done, err;
    logic [11:0]       result;
    logic              busy, en_adc;
    logic [7:0]        din_address;
    logic              adc_state = 1'b0;
    logic [11:0]       adc_out = '0;

    logic [NREQ-1:0]   req_b = '0;
    logic [4*NREQ-1:0] chan_b = '0;
    logic [NREQ-1:0]   grant_b, done_b, err_b;
    logic [11:0]       result_b;
    logic              busy_b, en_adc_b;
    logic [7:0]        din_address_b;
    logic              adc_state_b = 1'b0;

    adc_conv_arbiter #(.NREQ(NREQ), .DISCARD(DISCARD), .AVG_LOG2(AVG_A), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .chan(chan), .grant(grant), .done(done), .err(err),
        .result(result), .busy(busy), .en_adc(en_adc), .din_address(din_address),
        .adc_state(adc_state), .adc_out(adc_out)
    );

    adc_conv_arbiter #(.NREQ(NREQ), .DISCARD(DISCARD), .AVG_LOG2(5)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .chan(chan_b), .grant(grant_b), .done(done_b),
        .err(err_b), .result(result_b), .busy(busy_b), .en_adc(en_adc_b),
        .din_address(din_address_b), .adc_state(adc_state_b), .adc_out(12'hFFF)
    );

    // ADC core model: 6-cycle conversions while enabled, sample presented at the falling edge.
    int          cyc_n = 0;
    int          ph_a = 0;
    int          stall_n = 0;
    int          last_fall = 0;
    logic [11:0] nxt;
    logic [11:0] samp_q[$];
    logic [11:0] job_q[$];

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (!en_adc) begin
            ph_a      <= 0;
            adc_state <= 1'b0;
            job_q.delete();
        end else if (stall_n != 0 && job_q.size() >= stall_n) begin
            adc_state <= 1'b0;
        end else begin
            ph_a <= (ph_a == 5) ? 0 : ph_a + 1;
            if (ph_a == 1) begin
                adc_state <= 1'b1;
            end else if (ph_a == 4) begin
                nxt = (samp_q.size() > 0) ? samp_q.pop_front() : 12'($urandom_range(0, 4095));
                adc_state <= 1'b0;
                adc_out   <= nxt;
                job_q.push_back(nxt);
                last_fall <= cyc_n + 1;
            end
        end
    end

    int ph_b = 0;
    always @(posedge clk) begin
        if (!en_adc_b) begin
            ph_b        <= 0;
            adc_state_b <= 1'b0;
        end else begin
            ph_b <= (ph_b == 5) ? 0 : ph_b + 1;
            if (ph_b == 1) adc_state_b <= 1'b1;
            else if (ph_b == 4) adc_state_b <= 1'b0;
        end
    end

    int          total = 0;
    int          bad = 0;
    int          exp_ptr = 0;
    logic [11:0] last_result = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [11:0] exp_mean();
        int unsigned sum = 0;
        if (job_q.size() < DISCARD + NA) return 'x;
        for (int i = DISCARD; i < DISCARD + NA; i++) sum += job_q[i];
        return 12'(sum / NA);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_en_adc"}, en_adc, 0);
        check({tag, "_din"}, din_address, 8'hFF);
    endtask

    // Runs one job on dut to completion; exp_lat < 0 skips the grant-latency check.
    task automatic run_job(input int exp_lat, input bit exp_err);
        int              cyc;
        int              win;
        logic [NREQ-1:0] oh;
        logic [7:0]      exp_din;
        win = rr_pick(req, exp_ptr);
        oh  = '0;
        if (win >= 0) oh[win] = 1'b1;
        exp_din = (win >= 0) ? {chan[4*win +: 4], 4'b1000} : 8'hFF;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (grant == '0 && cyc < 20);
        check("grant_owner", grant, oh);
        if (exp_lat >= 0) check("arb_latency", cyc, exp_lat);
        check("din_setup", din_address, exp_din);
        check("en_setup", en_adc, 1);
        cyc = 0;
        while (done == '0 && err == '0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            check("grant_held", grant, oh);
            if (en_adc) check("din_conv", din_address, exp_din);
        end
        if (exp_err) begin
            check("err_pulse", err, oh);
            check("err_no_done", done, 0);
            check("err_result_kept", result, last_result);
        end else begin
            check("done_pulse", done, oh);
            check("done_no_err", err, 0);
            check("done_result", result, exp_mean());
            last_result = exp_mean();
            check("done_en_low", en_adc, 0);
            check("done_din_ff", din_address, 8'hFF);
        end
        check("end_busy", busy, 1);
        exp_ptr = (win + 1) % NREQ;
    endtask

    initial begin
        int cyc;
        int win;

        // Reset values
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_b_en", en_adc_b, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single job: two discarded samples then the mean of four
        samp_q = '{12'd100, 12'd200, 12'd10, 12'd20, 12'd30, 12'd40};
        chan[3:0] = 4'h5;
        req = 4'b0001;
        run_job(1, 1'b0);
        check("first_result_25", result, 12'd25);
        req = '0;
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("result_held", result, 12'd25);

        // Round robin with all requests held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
        last_result = '0;
        chan = {4'h3, 4'h2, 4'h1, 4'h0};
        req = 4'b1111;
        run_job(1, 1'b0);
        for (int j = 0; j < 4; j++) run_job(2, 1'b0);
        req = '0;
        repeat (2) @(negedge clk);

        // Watchdog: ADC stalls after three conversions
        stall_n = 3;
        req = 4'b0100;
        run_job(1, 1'b1);
        check("err_timing", cyc_n - last_fall, TMO + 1);
        req = '0;
        stall_n = 0;
        repeat (2) @(negedge clk);

        // Owner drops its request mid-conversion while requester 2 waits
        req = 4'b0110;
        win = rr_pick(req, exp_ptr);
        check("drop_owner_model", win, 1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (grant == '0 && cyc < 20);
        check("drop_owner_grant", grant, 4'b0010);
        repeat (12) @(negedge clk);
        req = 4'b0100;
        exp_ptr = 2;
        @(negedge clk);
        check("drop_idle_busy", busy, 0);
        check("drop_no_done", done, 0);
        check("drop_no_err", err, 0);
        check("drop_result_kept", result, last_result);
        run_job(1, 1'b0);
        req = '0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a conversion
        req = 4'b1000;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (grant == '0 && cyc < 20);
        check("rst_job_grant", grant, 4'b1000);
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_idle_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
        last_result = '0;
        req = 4'b1010;
        run_job(1, 1'b0);
        req = '0;
        repeat (2) @(negedge clk);

        // Wide instance: 32 full-scale samples must not wrap the accumulator
        req_b = 4'b0001;
        cyc = 0;
        while (done_b == '0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("wide_done", done_b, 4'b0001);
        check("wide_result", result_b, 12'hFFF);
        check("wide_no_err", err_b, 0);
        req_b = '0;

        // Random request patterns and channels
        for (int j = 0; j < 6; j++) begin
            chan = 16'($urandom);
            req = 4'($urandom_range(1, 15));
            run_job(1, 1'b0);
            req = '0;
            repeat (2) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
